// File: rtl/btb_predictor_if.sv
// Fetch-lookup, resolve-update and flush signals between the pipeline and btb_predictor.
interface btb_predictor_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] lk_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_next_pc;

  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_is_jump;
  logic [XLEN-1:0] upd_pred_next;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  logic            flush_all;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
           upd_pred_next, flush_all,
    input  pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
           upd_pred_next, flush_all,
    output pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: next-PC prediction and resolve-time training.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module btb_predictor #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 16,
  parameter logic [1:0]  RESET_CNT = 2'b01
) (
  input  logic           clk,
  input  logic           rst,
  btb_predictor_if.slave bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]    stat_lookups,
  output logic [31:0]    stat_hits,
  output logic [31:0]    stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][XLEN-1:0]  target_q, target_d;
  logic [ENTRIES-1:0][1:0]       cnt_q, cnt_d;
  logic [ENTRIES-1:0]            jump_q, jump_d;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [XLEN-1:0]  actual_next;
  logic             mispredict_c;

  // Instruction alignment bits never take part in indexing or tagging.
  logic unused_align_bits;
  assign unused_align_bits = &{1'b0, bus.lk_pc[1:0], bus.upd_pc[1:0]};

  // Fetch-side lookup against registered table state.
  always_comb begin
    lk_idx   = bus.lk_pc[IDX_W+1:2];
    lk_tag   = bus.lk_pc[XLEN-1:IDX_W+2];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && (jump_q[lk_idx] || cnt_q[lk_idx][1]);

    bus.pred_hit     = lk_hit;
    bus.pred_taken   = lk_taken;
    bus.pred_next_pc = lk_taken ? target_q[lk_idx] : (bus.lk_pc + XLEN'(4));
  end

  // Resolve-side check; redirect_pc always carries the architecturally correct next PC.
  always_comb begin
    upd_idx      = bus.upd_pc[IDX_W+1:2];
    upd_tag      = bus.upd_pc[XLEN-1:IDX_W+2];
    upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    actual_next  = bus.upd_taken ? bus.upd_target : (bus.upd_pc + XLEN'(4));
    mispredict_c = bus.upd_valid && (actual_next != bus.upd_pred_next);

    bus.mispredict  = mispredict_c;
    bus.redirect_pc = actual_next;
  end

  // Table training; flush beats a same-cycle update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    jump_d   = jump_q;

    if (bus.flush_all) begin
      valid_d = '0;
      cnt_d   = {ENTRIES{RESET_CNT}};
    end else if (bus.upd_valid) begin
      if (upd_hit) begin
        if (bus.upd_taken) begin
          cnt_d[upd_idx]    = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : (cnt_q[upd_idx] + 2'd1);
          target_d[upd_idx] = bus.upd_target;
        end else begin
          cnt_d[upd_idx]    = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : (cnt_q[upd_idx] - 2'd1);
        end
        jump_d[upd_idx] = bus.upd_is_jump;
      end else if (bus.upd_taken) begin
        // Allocation evicts whatever aliased entry occupied this index.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bus.upd_target;
        cnt_d[upd_idx]    = bus.upd_is_jump ? 2'b11 : 2'b10;
        jump_d[upd_idx]   = bus.upd_is_jump;
      end
    end
  end

  // Table state; tag/target/jump are qualified by valid and need no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      cnt_q   <= {ENTRIES{RESET_CNT}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      jump_q   <= jump_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Free-running event counters, wrapping at 2^32 and untouched by flush_all.
  always_comb begin
    stat_lookups_d     = stat_lookups_q + 32'd1;
    stat_hits_d        = stat_hits_q + 32'(lk_hit);
    stat_mispredicts_d = stat_mispredicts_q + 32'(mispredict_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_lookups_q     <= '0;
      stat_hits_q        <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_hits_q        <= stat_hits_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_hits        = stat_hits_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (default 16-entry, 32-bit configuration).
module tb_btb_predictor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  btb_predictor_if #(.XLEN(32)) bus ();

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispredicts;
`endif

  btb_predictor #(
    .XLEN     (32),
    .ENTRIES  (16),
    .RESET_CNT(2'b01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_hits       (stat_hits),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic j, input logic [31:0] pn);
    bus.upd_valid     = v;
    bus.upd_pc        = pc;
    bus.upd_taken     = tk;
    bus.upd_target    = tgt;
    bus.upd_is_jump   = j;
    bus.upd_pred_next = pn;
  endtask

  task automatic idle_upd();
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Lookup after the combinational settle; checks hit, taken and next PC.
  task automatic expect_lookup(input string tag, input logic [31:0] pc, input logic hit,
                               input logic tk, input logic [31:0] nxt);
    bus.lk_pc = pc;
    #1;
    check_eq({tag, ".hit"},   32'(bus.pred_hit),   32'(hit));
    check_eq({tag, ".taken"}, 32'(bus.pred_taken), 32'(tk));
    check_eq({tag, ".next"},  bus.pred_next_pc,    nxt);
  endtask

  task automatic expect_resolve(input string tag, input logic mp, input logic [31:0] rd);
    #1;
    check_eq({tag, ".mispredict"}, 32'(bus.mispredict), 32'(mp));
    check_eq({tag, ".redirect"},   bus.redirect_pc,     rd);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    bus.flush_all = 1'b0;
    bus.lk_pc     = 32'h100;
    idle_upd();

    // Reset held two cycles.
    tick();
    tick();
    rst = 1'b1;
    expect_lookup("reset", 32'h100, 1'b0, 1'b0, 32'h104);
    check_eq("reset.mispredict", 32'(bus.mispredict), 32'h0);

    // Idle resolve port never flags even with disagreeing inputs.
    drive_upd(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    expect_resolve("idle", 1'b0, 32'h200);

    // First taken resolve allocates; lookup in the same cycle sees the old table.
    drive_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    expect_resolve("alloc", 1'b1, 32'h200);
    expect_lookup("alloc_same_cycle", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();
    idle_upd();
    expect_lookup("alloc_next", 32'h100, 1'b1, 1'b1, 32'h200);

    // Not-taken twice: 10 -> 01 -> 00; target must survive a not-taken update.
    drive_upd(1'b1, 32'h100, 1'b0, 32'h0000BAD0, 1'b0, 32'h200);
    expect_resolve("nt1", 1'b1, 32'h104);
    tick();
    idle_upd();
    expect_lookup("nt1_look", 32'h100, 1'b1, 1'b0, 32'h104);
    drive_upd(1'b1, 32'h100, 1'b0, 32'h0000BAD0, 1'b0, 32'h104);
    expect_resolve("nt2", 1'b0, 32'h104);
    tick();
    idle_upd();
    expect_lookup("nt2_look", 32'h100, 1'b1, 1'b0, 32'h104);

    // From 00 one taken reaches 01 (still not-taken), a second reaches 10.
    drive_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick();
    idle_upd();
    expect_lookup("sat_low", 32'h100, 1'b1, 1'b0, 32'h104);
    drive_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick();
    idle_upd();
    expect_lookup("to_10", 32'h100, 1'b1, 1'b1, 32'h200);

    // Saturate at 11 then one not-taken leaves 10, still taken to the old target.
    drive_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h200);
    tick();
    tick();
    drive_upd(1'b1, 32'h100, 1'b0, 32'h0000BAD0, 1'b0, 32'h200);
    tick();
    idle_upd();
    expect_lookup("sat_high", 32'h100, 1'b1, 1'b1, 32'h200);

    // Alias 0x140 shares index 0 with 0x100 but has a different tag.
    expect_lookup("alias_miss", 32'h140, 1'b0, 1'b0, 32'h144);
    drive_upd(1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    expect_resolve("alias_upd", 1'b1, 32'h300);
    tick();
    idle_upd();
    expect_lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    expect_lookup("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);

    // Not-taken miss allocates nothing.
    drive_upd(1'b1, 32'h104, 1'b0, 32'h900, 1'b0, 32'h108);
    expect_resolve("nt_miss", 1'b0, 32'h108);
    tick();
    idle_upd();
    expect_lookup("nt_miss_look", 32'h104, 1'b0, 1'b0, 32'h108);

    // Jump entry keeps predicting taken after its counter drains to 00.
    drive_upd(1'b1, 32'h180, 1'b1, 32'h40, 1'b1, 32'h184);
    tick();
    idle_upd();
    expect_lookup("jump", 32'h180, 1'b1, 1'b1, 32'h40);
    drive_upd(1'b1, 32'h180, 1'b0, 32'h40, 1'b1, 32'h40);
    expect_resolve("jump_nt", 1'b1, 32'h184);
    tick();
    tick();
    tick();
    idle_upd();
    expect_lookup("jump_drained", 32'h180, 1'b1, 1'b1, 32'h40);
    // Clearing is_jump exposes the drained counter.
    drive_upd(1'b1, 32'h180, 1'b0, 32'h40, 1'b0, 32'h40);
    tick();
    idle_upd();
    expect_lookup("jump_cleared", 32'h180, 1'b1, 1'b0, 32'h184);

    // PC+4 wraps modulo 2^32 on both paths.
    expect_lookup("wrap_lk", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    drive_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_resolve("wrap_upd", 1'b0, 32'h0);
    idle_upd();

    // Second index gets a live entry before the flush.
    drive_upd(1'b1, 32'h104, 1'b1, 32'h600, 1'b0, 32'h108);
    tick();
    idle_upd();
    expect_lookup("idx1", 32'h104, 1'b1, 1'b1, 32'h600);

    // Flush beats a simultaneous taken allocation.
    bus.flush_all = 1'b1;
    drive_upd(1'b1, 32'h1C0, 1'b1, 32'h500, 1'b0, 32'h1C4);
    tick();
    bus.flush_all = 1'b0;
    idle_upd();
    expect_lookup("flush_1c0", 32'h1C0, 1'b0, 1'b0, 32'h1C4);
    expect_lookup("flush_180", 32'h180, 1'b0, 1'b0, 32'h184);
    expect_lookup("flush_104", 32'h104, 1'b0, 1'b0, 32'h108);

    // Mid-operation reset discards the in-flight update and the live entry.
    drive_upd(1'b1, 32'h104, 1'b1, 32'h600, 1'b0, 32'h108);
    tick();
    idle_upd();
    drive_upd(1'b1, 32'h100, 1'b1, 32'h700, 1'b0, 32'h104);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle_upd();
    expect_lookup("rst_100", 32'h100, 1'b0, 1'b0, 32'h104);
    expect_lookup("rst_104", 32'h104, 1'b0, 1'b0, 32'h108);

`ifdef BTB_STATS_EN
    check_eq("stat_lookups_rst", stat_lookups, 32'h0);
    check_eq("stat_hits_rst", stat_hits, 32'h0);
    tick();
    tick();
    check_eq("stat_lookups_2", stat_lookups, 32'd2);
    check_eq("stat_hits_2", stat_hits, 32'd0);
    check_eq("stat_mispredicts_2", stat_mispredicts, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
